// File: rtl/rng_sop_reader_pkg.sv
// Shared constants and types for the RNG secure-output-port reader.
package rng_sop_reader_pkg;
  localparam int SOP_WIDTH = 128;
  localparam int SOP_WORDS = 4;
  localparam int WORD_W    = SOP_WIDTH / SOP_WORDS;

  typedef enum logic [1:0] {
    SOP_IDLE       = 2'd0,
    SOP_WAIT_VALID = 2'd1,
    SOP_WAIT_DROP  = 2'd2
  } sop_state_e;

  typedef logic [SOP_WIDTH-1:0]              sop_blk_t;
  typedef logic [SOP_WORDS-1:0][WORD_W-1:0]  sop_words_t;
endpackage

// File: rtl/rng_sop_reader_if.sv
// SOP block handshake plus the downstream 32-bit word stream.
interface rng_sop_reader_if;
  import rng_sop_reader_pkg::*;

  logic              sop_valid;
  sop_blk_t          sop_data;
  logic              rd_sop;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_data;

  modport master (input  sop_valid, sop_data, out_ready,
                  output rd_sop, out_valid, out_data);
  modport slave  (output sop_valid, sop_data, out_ready,
                  input  rd_sop, out_valid, out_data);
endinterface

// File: rtl/rng_sop_fifo.sv
// 128-bit x DEPTH synchronous FIFO; pointers carry one wrap bit so level is a plain difference.
module rng_sop_fifo
  import rng_sop_reader_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int LVL_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_push,
  input  sop_blk_t         i_data,
  input  logic             i_pop,
  output sop_blk_t         o_head,
  output logic             o_empty,
  output logic             o_full,
  output logic [LVL_W-1:0] o_level
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  sop_blk_t         r_mem [DEPTH];
  logic [LVL_W-1:0] r_wp, r_rp;
  logic             w_push, w_pop;

  assign w_push  = i_push && !o_full && !i_flush;
  assign w_pop   = i_pop && !o_empty && !i_flush;
  assign o_level = r_wp - r_rp;
  assign o_empty = (r_wp == r_rp);
  assign o_full  = (o_level == LVL_W'(DEPTH));
  assign o_head  = r_mem[r_rp[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp <= '0;
      r_rp <= '0;
    end else if (i_flush) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp[AW-1:0]] <= i_data;
  end
endmodule

// File: rtl/rng_sop_reader.sv
// Fetch FSM, timeout, repeated-block check and 128->32 unpacker in front of rng_sop_fifo.
module rng_sop_reader
  import rng_sop_reader_pkg::*;
#(
  parameter int DEPTH   = 2,
  parameter int LVL_W   = 2,
  parameter int TO_W    = 16,
  parameter int TIMEOUT = 40000
) (
  input  logic                 rng_clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 rng_sw_reset,
  input  logic                 err_clr,
  rng_sop_reader_if.master     bus,
  output logic [LVL_W-1:0]     fifo_level,
  output logic                 dup_err,
  output logic                 timeout_err
);
  localparam int IDX_W = $clog2(SOP_WORDS);

  sop_state_e       r_state, w_state_nxt;
  logic [TO_W-1:0]  r_cnt;
  sop_blk_t         r_prev;
  logic             r_prev_vld;
  logic             r_rd_sop, r_dup_err, r_to_err;
  logic [IDX_W-1:0] r_idx;

  logic       w_cap, w_dup, w_push, w_to, w_xfer, w_pop, w_cnt_end;
  logic       w_empty, w_full;
  sop_blk_t   w_head;
  sop_words_t w_words;

  // A capture coinciding with the soft reset is discarded outright.
  assign w_cap     = (r_state == SOP_WAIT_VALID) && bus.sop_valid && !rng_sw_reset;
  assign w_dup     = w_cap && r_prev_vld && (bus.sop_data == r_prev);
  assign w_push    = w_cap && !w_dup;
  assign w_cnt_end = (r_cnt == TO_W'(TIMEOUT - 1));
  assign w_to      = (r_state == SOP_WAIT_VALID) && !bus.sop_valid && w_cnt_end && !rng_sw_reset;
  assign w_xfer    = bus.out_valid && bus.out_ready;
  assign w_pop     = w_xfer && (r_idx == IDX_W'(SOP_WORDS - 1));

  rng_sop_fifo #(.DEPTH(DEPTH), .LVL_W(LVL_W)) u_fifo (
    .clk     (rng_clk),
    .rst_n   (rst_n),
    .i_flush (rng_sw_reset),
    .i_push  (w_push),
    .i_data  (bus.sop_data),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_level (fifo_level)
  );

  assign w_words       = w_head;
  assign bus.out_valid = !w_empty;
  assign bus.out_data  = w_empty ? '0 : w_words[r_idx];
  assign bus.rd_sop    = r_rd_sop;
  assign dup_err       = r_dup_err;
  assign timeout_err   = r_to_err;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      SOP_IDLE:
        if (enable && !w_full && !r_dup_err && !r_to_err) w_state_nxt = SOP_WAIT_VALID;
      SOP_WAIT_VALID:
        if (bus.sop_valid)  w_state_nxt = SOP_WAIT_DROP;
        else if (w_cnt_end) w_state_nxt = SOP_IDLE;
      SOP_WAIT_DROP:
        // Wait for the RNG to drop valid so the same block is never read twice.
        if (!bus.sop_valid) w_state_nxt = SOP_IDLE;
      default: w_state_nxt = SOP_IDLE;
    endcase
    if (rng_sw_reset) w_state_nxt = SOP_IDLE;
  end

  always_ff @(posedge rng_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= SOP_IDLE;
      r_cnt      <= '0;
      r_prev     <= '0;
      r_prev_vld <= 1'b0;
      r_rd_sop   <= 1'b0;
      r_idx      <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_rd_sop <= w_cap;
      if (r_state == SOP_WAIT_VALID && w_state_nxt == SOP_WAIT_VALID) r_cnt <= r_cnt + 1'b1;
      else                                                            r_cnt <= '0;
      if (rng_sw_reset) begin
        r_prev_vld <= 1'b0;
        r_idx      <= '0;
      end else begin
        if (w_push) begin
          r_prev     <= bus.sop_data;
          r_prev_vld <= 1'b1;
        end
        if (w_xfer) r_idx <= r_idx + 1'b1;
      end
    end
  end

  // Sticky errors: a new error in the clear cycle takes precedence.
  always_ff @(posedge rng_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dup_err <= 1'b0;
      r_to_err  <= 1'b0;
    end else begin
      if (err_clr) begin
        r_dup_err <= 1'b0;
        r_to_err  <= 1'b0;
      end
      if (w_dup) r_dup_err <= 1'b1;
      if (w_to)  r_to_err  <= 1'b1;
    end
  end
endmodule

// File: tb/tb_rng_sop_reader.sv
// Directed bench: stimulus queues expected words, a negedge monitor pops and compares them.
module tb_rng_sop_reader;
  import rng_sop_reader_pkg::*;

  localparam int DEPTH = 2;
  localparam int LVL_W = 2;

  logic             rng_clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             enable = 1'b0;
  logic             rng_sw_reset = 1'b0;
  logic             err_clr = 1'b0;
  logic [LVL_W-1:0] fifo_level;
  logic             dup_err, timeout_err;

  rng_sop_reader_if bus();

  int          n_vec = 0;
  int          n_err = 0;
  int          rd_cnt = 0;
  int          rd0;
  logic [31:0] exp_q [$];

  always #5 rng_clk = ~rng_clk;

  rng_sop_reader #(.DEPTH(DEPTH), .LVL_W(LVL_W), .TO_W(16), .TIMEOUT(16)) dut (
    .rng_clk      (rng_clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .rng_sw_reset (rng_sw_reset),
    .err_clr      (err_clr),
    .bus          (bus),
    .fifo_level   (fifo_level),
    .dup_err      (dup_err),
    .timeout_err  (timeout_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge rng_clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic push_blk(input sop_blk_t b);
    for (int i = 0; i < SOP_WORDS; i++) exp_q.push_back(b[32*i +: 32]);
  endtask

  task automatic wait_rd(input string name);
    int t = 0;
    do begin
      tick();
      t++;
    end while (bus.rd_sop !== 1'b1 && t < 60);
    chk(name, {31'd0, bus.rd_sop}, 32'd1);
  endtask

  always @(negedge rng_clk) begin
    if (rst_n && bus.rd_sop === 1'b1) rd_cnt++;
  end

  always @(negedge rng_clk) begin
    if (rst_n && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL out_word: got %h expected no word", bus.out_data);
      end else begin
        chk("out_word", bus.out_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.sop_valid = 1'b0;
    bus.sop_data  = '0;
    bus.out_ready = 1'b0;
    ticks(3);
    rst_n = 1'b1;
    tick();
    chk("rst fifo_level", 32'(fifo_level), 0);
    chk("rst out_valid", {31'd0, bus.out_valid}, 0);
    chk("rst out_data", bus.out_data, 0);
    chk("rst rd_sop", {31'd0, bus.rd_sop}, 0);
    chk("rst dup_err", {31'd0, dup_err}, 0);
    chk("rst timeout_err", {31'd0, timeout_err}, 0);

    // 1: single block, LS word first
    bus.out_ready = 1'b1;
    bus.sop_data  = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    exp_q.push_back(32'h03020100);
    exp_q.push_back(32'h07060504);
    exp_q.push_back(32'h0B0A0908);
    exp_q.push_back(32'h0F0E0D0C);
    bus.sop_valid = 1'b1;
    rd0 = rd_cnt;
    enable = 1'b1;
    wait_rd("t1 rd_sop");
    chk("t1 level at rd", 32'(fifo_level), 1);
    enable = 1'b0;
    bus.sop_valid = 1'b0;
    ticks(8);
    chk("t1 rd count", rd_cnt - rd0, 1);
    chk("t1 level end", 32'(fifo_level), 0);
    chk("t1 out_valid end", {31'd0, bus.out_valid}, 0);
    chk("t1 drained", exp_q.size(), 0);

    // 2: valid held high after rd_sop reads once
    bus.sop_data = 128'h44444444_33333333_22222222_11111111;
    push_blk(bus.sop_data);
    bus.sop_valid = 1'b1;
    rd0 = rd_cnt;
    enable = 1'b1;
    wait_rd("t2 rd_sop");
    ticks(10);
    chk("t2 single rd", rd_cnt - rd0, 1);
    bus.sop_valid = 1'b0;
    tick();
    bus.sop_data = 128'h88888888_77777777_66666666_55555555;
    push_blk(bus.sop_data);
    bus.sop_valid = 1'b1;
    wait_rd("t2 rd after 0->1");
    enable = 1'b0;
    bus.sop_valid = 1'b0;
    ticks(8);
    chk("t2 rd count", rd_cnt - rd0, 2);
    chk("t2 drained", exp_q.size(), 0);

    // 3: repeated block dropped, fetch stalls until err_clr
    bus.out_ready = 1'b0;
    bus.sop_data  = {4{32'hA5A5A5A5}};
    push_blk(bus.sop_data);
    bus.sop_valid = 1'b1;
    rd0 = rd_cnt;
    enable = 1'b1;
    wait_rd("t3 rd first");
    bus.sop_valid = 1'b0;
    tick();
    bus.sop_valid = 1'b1;
    wait_rd("t3 rd dup");
    chk("t3 dup_err", {31'd0, dup_err}, 1);
    chk("t3 level after dup", 32'(fifo_level), 1);
    bus.sop_valid = 1'b0;
    bus.sop_data  = 128'hCAFE0003_CAFE0002_CAFE0001_CAFE0000;
    push_blk(bus.sop_data);
    tick();
    bus.sop_valid = 1'b1;
    ticks(10);
    chk("t3 no rd while dup_err", rd_cnt - rd0, 2);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t3 dup_err cleared", {31'd0, dup_err}, 0);
    wait_rd("t3 rd after clr");
    chk("t3 level after clr", 32'(fifo_level), 2);
    enable = 1'b0;
    bus.sop_valid = 1'b0;
    bus.out_ready = 1'b1;
    ticks(12);
    chk("t3 rd count", rd_cnt - rd0, 3);
    chk("t3 level end", 32'(fifo_level), 0);
    chk("t3 drained", exp_q.size(), 0);

    // 4: saturation at DEPTH, refetch only after the 4th word frees an entry
    bus.out_ready = 1'b0;
    bus.sop_data  = 128'h00000013_00000012_00000011_00000010;
    push_blk(bus.sop_data);
    bus.sop_valid = 1'b1;
    rd0 = rd_cnt;
    enable = 1'b1;
    wait_rd("t4 rd1");
    chk("t4 level 1", 32'(fifo_level), 1);
    bus.sop_valid = 1'b0;
    tick();
    bus.sop_data = 128'h00000023_00000022_00000021_00000020;
    push_blk(bus.sop_data);
    bus.sop_valid = 1'b1;
    wait_rd("t4 rd2");
    chk("t4 level 2", 32'(fifo_level), 2);
    bus.sop_valid = 1'b0;
    tick();
    bus.sop_data = 128'h00000033_00000032_00000031_00000030;
    push_blk(bus.sop_data);
    bus.sop_valid = 1'b1;
    ticks(10);
    chk("t4 saturated rd count", rd_cnt - rd0, 2);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    ticks(5);
    chk("t4 no refetch after 1 word", rd_cnt - rd0, 2);
    chk("t4 level after 1 word", 32'(fifo_level), 2);
    bus.out_ready = 1'b1;
    ticks(3);
    bus.out_ready = 1'b0;
    chk("t4 level after 4th word", 32'(fifo_level), 1);
    wait_rd("t4 rd3");
    chk("t4 level refilled", 32'(fifo_level), 2);
    enable = 1'b0;
    bus.sop_valid = 1'b0;
    bus.out_ready = 1'b1;
    ticks(16);
    chk("t4 rd count", rd_cnt - rd0, 3);
    chk("t4 level end", 32'(fifo_level), 0);
    chk("t4 drained", exp_q.size(), 0);

    // 5: timeout after 16 cycles of WAIT_VALID
    bus.sop_valid = 1'b0;
    rd0 = rd_cnt;
    enable = 1'b1;
    ticks(16);
    chk("t5 no timeout yet", {31'd0, timeout_err}, 0);
    tick();
    chk("t5 timeout_err", {31'd0, timeout_err}, 1);
    ticks(5);
    chk("t5 no rd", rd_cnt - rd0, 0);
    chk("t5 timeout sticky", {31'd0, timeout_err}, 1);
    enable = 1'b0;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t5 timeout cleared", {31'd0, timeout_err}, 0);

    // 6: soft reset on a capture cycle flushes everything
    bus.out_ready = 1'b0;
    bus.sop_data  = 128'hEEEE0003_EEEE0002_EEEE0001_EEEE0000;
    bus.sop_valid = 1'b1;
    rd0 = rd_cnt;
    enable = 1'b1;
    wait_rd("t6 rd pre-flush");
    chk("t6 level pre-flush", 32'(fifo_level), 1);
    bus.sop_valid = 1'b0;
    tick();
    bus.sop_data  = 128'hFFFF0003_FFFF0002_FFFF0001_FFFF0000;
    bus.sop_valid = 1'b1;
    tick();
    rng_sw_reset = 1'b1;
    tick();
    rng_sw_reset = 1'b0;
    enable = 1'b0;
    bus.sop_valid = 1'b0;
    chk("t6 rd_sop after flush", {31'd0, bus.rd_sop}, 0);
    chk("t6 level after flush", 32'(fifo_level), 0);
    chk("t6 out_valid after flush", {31'd0, bus.out_valid}, 0);
    ticks(4);
    chk("t6 rd count", rd_cnt - rd0, 1);
    bus.sop_data = 128'hEEEE0003_EEEE0002_EEEE0001_EEEE0000;
    push_blk(bus.sop_data);
    bus.sop_valid = 1'b1;
    bus.out_ready = 1'b1;
    enable = 1'b1;
    wait_rd("t6 rd post-flush");
    chk("t6 no dup after flush", {31'd0, dup_err}, 0);
    enable = 1'b0;
    bus.sop_valid = 1'b0;
    ticks(8);
    chk("t6 level end", 32'(fifo_level), 0);
    chk("t6 drained", exp_q.size(), 0);

    // async reset with a block buffered
    bus.out_ready = 1'b0;
    bus.sop_data  = 128'h12345678_9ABCDEF0_0FEDCBA9_87654321;
    bus.sop_valid = 1'b1;
    enable = 1'b1;
    wait_rd("ar rd");
    enable = 1'b0;
    bus.sop_valid = 1'b0;
    tick();
    chk("ar level before", 32'(fifo_level), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar level", 32'(fifo_level), 0);
    chk("ar out_valid", {31'd0, bus.out_valid}, 0);
    chk("ar rd_sop", {31'd0, bus.rd_sop}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
